// File: rtl/ramp_sequencer.sv
// ramp_sequencer: runs a ramp generator as a batch of repeated ramps.
// A command (repeat count and pause length) is accepted over valid/ready.
// The block pulses the ramp start input and waits for the ramp's
// end-of-sequence. It then waits a programmable number of 10 ms ticks and
// repeats. A tick-based watchdog flags a ramp that never finishes.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o  command handshake (ready only in IDLE)
//   cmd_reps_i, cmd_pause_i  ramps to run, ticks to pause between ramps
//   abort_i                  cancel the current batch
//   tick_i                   1-cycle 10 ms timebase pulse
//   ramp_eos_i               ramp end-of-sequence (level or pulse)
//   ramp_start_o             1-cycle start pulse to the ramp
//   busy_o, done_o, err_o    status: busy, batch done pulse, sticky timeout
//   reps_done_o              ramps completed in the current/last batch
module ramp_sequencer #(
  parameter int unsigned RepWidth   = 8,
  parameter int unsigned PauseWidth = 8,
  parameter int unsigned WdogWidth  = 12,
  parameter int unsigned WdogTicks  = 2100
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [RepWidth-1:0]   cmd_reps_i,
  input  logic [PauseWidth-1:0] cmd_pause_i,
  input  logic                abort_i,
  input  logic                tick_i,
  input  logic                ramp_eos_i,
  output logic                ramp_start_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [RepWidth-1:0] reps_done_o
);

  localparam logic [WdogWidth-1:0] WdogLimit = WdogWidth'(WdogTicks);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_PAUSE,
    S_FINISH,
    S_ERROR
  } state_t;

  state_t                r_state;
  logic [RepWidth-1:0]   r_reps;
  logic [RepWidth-1:0]   r_reps_done;
  logic [PauseWidth-1:0] r_pause;
  logic [PauseWidth-1:0] r_pause_cnt;
  logic [WdogWidth-1:0]  r_wdog;
  logic                  r_eos_prev;
  logic                  r_ramp_start;
  logic                  r_done;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_eos_evt;
  logic                  w_wdog_exp;
  logic [WdogWidth-1:0]  w_wdog_inc;
  logic [RepWidth-1:0]   w_reps_inc;

  assign w_accept   = cmd_valid_i & (r_state == S_IDLE);
  // Only a rising edge seen while RUN counts as a completed ramp.
  assign w_eos_evt  = (r_state == S_RUN) & ramp_eos_i & ~r_eos_prev;
  assign w_wdog_inc = r_wdog + WdogWidth'(1);
  assign w_wdog_exp = tick_i & (w_wdog_inc == WdogLimit);
  // Completed count never exceeds the requested count.
  assign w_reps_inc = (r_reps_done == r_reps) ? r_reps_done
                                              : r_reps_done + RepWidth'(1);

  // Sequencer state, counters and registered pulse/flag outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_reps       <= '0;
      r_reps_done  <= '0;
      r_pause      <= '0;
      r_pause_cnt  <= '0;
      r_wdog       <= '0;
      r_eos_prev   <= 1'b1;
      r_ramp_start <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_eos_prev   <= ramp_eos_i;
      r_ramp_start <= 1'b0;
      r_done       <= 1'b0;
      if ((r_state != S_IDLE) && abort_i) begin
        // Abort wins over eos and timeout; counters and err hold.
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_reps      <= cmd_reps_i;
              r_pause     <= cmd_pause_i;
              r_reps_done <= '0;
              r_err       <= 1'b0;
              if (cmd_reps_i == '0) begin
                r_state <= S_FINISH;
                r_done  <= 1'b1;
              end else begin
                r_state      <= S_START;
                r_ramp_start <= 1'b1;
              end
            end
          end
          S_START: begin
            r_wdog  <= '0;
            r_state <= S_RUN;
          end
          S_RUN: begin
            if (w_eos_evt) begin
              r_reps_done <= w_reps_inc;
              if (w_reps_inc == r_reps) begin
                r_state <= S_FINISH;
                r_done  <= 1'b1;
              end else if (r_pause == '0) begin
                r_state      <= S_START;
                r_ramp_start <= 1'b1;
              end else begin
                r_pause_cnt <= r_pause;
                r_state     <= S_PAUSE;
              end
            end else if (w_wdog_exp) begin
              r_state <= S_ERROR;
              r_err   <= 1'b1;
            end else if (tick_i) begin
              r_wdog <= w_wdog_inc;
            end
          end
          S_PAUSE: begin
            if (tick_i) begin
              r_pause_cnt <= r_pause_cnt - PauseWidth'(1);
              if (r_pause_cnt == PauseWidth'(1)) begin
                r_state      <= S_START;
                r_ramp_start <= 1'b1;
              end
            end
          end
          S_FINISH: r_state <= S_IDLE;
          S_ERROR:  r_state <= S_IDLE;
          default:  r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign cmd_ready_o  = (r_state == S_IDLE);
  assign busy_o       = (r_state != S_IDLE);
  assign ramp_start_o = r_ramp_start;
  assign done_o       = r_done;
  assign err_o        = r_err;
  assign reps_done_o  = r_reps_done;

endmodule

// File: doc/ramp_sequencer.md
Name: ramp_sequencer

Overview:
Controller that runs the ramp generator as a scheduled batch of repeated ramps. It accepts a command over a valid/ready handshake and pulses the ramp's start input. It then waits for the ramp's end-of-sequence, inserts a programmable pause measured in 10 ms ticks, and repeats. A tick-based watchdog reports a ramp that never finishes.

Parameters:
RepWidth, 8, width of repeat-count field and reps_done_o
PauseWidth, 8, width of pause field (pause length in tick_i periods)
WdogWidth, 12, width of watchdog counter
WdogTicks, 2100, tick_i periods allowed in RUN before timeout (must fit WdogWidth)

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  high when a command can be accepted (state IDLE)
cmd_reps_i  in  RepWidth  number of ramps to run
cmd_pause_i  in  PauseWidth  ticks to wait between ramps
abort_i  in  1  cancel current batch
tick_i  in  1  1-cycle 10 ms timebase pulse
ramp_eos_i  in  1  ramp end-of-sequence (level or pulse)
ramp_start_o  out  1  1-cycle start pulse to ramp
busy_o  out  1  state != IDLE
done_o  out  1  1-cycle pulse, batch completed normally
err_o  out  1  sticky watchdog timeout flag
reps_done_o  out  RepWidth  ramps completed in current/last batch

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - state=IDLE, ramp_start_o=0, done_o=0, err_o=0, reps_done_o=0.
  - All counters and latched fields = 0.
  - ramp_eos_i edge register = 1, so an eos level already high at reset is not taken as an edge.
  - cmd_ready_o=1 and busy_o=0 (both decoded from state).
- Handshake: a command is accepted on the clk_i edge where cmd_valid_i & cmd_ready_o.
  - On acceptance, cmd_reps_i and cmd_pause_i are latched, reps_done_o is cleared and err_o is cleared.
  - Inputs are ignored in every other state.
- EOS detection: ramp_eos_i is registered each cycle. An "eos event" is a rising edge (cur=1, prev=0) that occurs while in RUN.
- States:
  - IDLE: on accept, go to FINISH if reps==0, else START.
  - START: ramp_start_o=1 for exactly this cycle; watchdog cleared; next state RUN.
  - RUN: watchdog increments on each tick_i.
    - On an eos event: reps_done_o increments.
      - If the new value == reps, go FINISH.
      - Else if pause==0, go START.
      - Else load the pause counter with pause and go PAUSE.
    - If the watchdog reaches WdogTicks with no eos event, go ERROR.
  - PAUSE: the pause counter decrements on tick_i. The tick that takes it 1->0 moves the state to START on the next cycle.
  - FINISH: done_o=1 for this cycle; next state IDLE.
  - ERROR: err_o set (sticky); done_o stays 0; next state IDLE.
- Priorities:
  - abort_i high in any non-IDLE state sends the state to IDLE on the next edge. No done_o; err_o unchanged; reps_done_o holds.
  - abort_i beats an eos event or timeout in the same cycle.
  - An eos event beats a timeout in the same cycle.
- Start-to-start spacing: minimum 2 cycles (RUN->START when pause==0), plus the ramp's own latency.
- reps_done_o saturates at reps and never wraps. cmd_reps_i = 2^RepWidth-1 is legal.
- Reset mid-batch: immediate return to reset values. No ramp_start_o is issued afterwards until a new command is accepted.
- ramp_start_o, done_o and err_o are registered outputs (glitch-free).

Test Plan:
- Reset release, no command -> cmd_ready_o=1, busy_o=0, ramp_start_o stays 0 for 1000 cycles.
- cmd reps=3, pause=2, model ramp eos 50 ticks after each start -> exactly 3 ramp_start_o pulses, each 1 cycle; ≥2 tick_i between eos and the next start; done_o pulses once; reps_done_o=3; busy_o falls the cycle after done_o.
- cmd reps=0 -> no ramp_start_o; done_o one cycle after acceptance (FINISH) then IDLE; reps_done_o=0.
- cmd reps=2, pause=0, eos never asserted, WdogTicks=2100 -> err_o=1 after 2100 ticks in RUN; done_o=0; reps_done_o=0; next accepted cmd clears err_o.
- cmd reps=5, abort_i pulsed in the PAUSE after the 2nd ramp -> IDLE next cycle; no further ramp_start_o; reps_done_o=2; err_o=0; done_o=0.
- eos held high through reset and into RUN, plus eos and watchdog expiry in the same cycle -> the held level is not counted; the simultaneous case counts as eos (reps_done_o increments, err_o stays 0).
